// File: rtl/branch_ctrl.sv
// branch_ctrl: conditional-jump sequencer for the pipeline.
//   Owns the CPSR flag register {N,Z,C,V}, counts in-flight flag writers,
//   stalls decode until a jump's flags are final, evaluates the condition,
//   hands a redirect to fetch and then flushes IF/ID for FLUSH_CYCLES cycles.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   id_valid/id_is_jmp       decode holds a valid jump
//   id_cond, id_target       jump condition code and target address
//   flag_issue               flag-setting instruction leaves decode
//   flag_wr_en/flag_wr_data  flag write-back and new {N,Z,C,V}
//   redirect_ready           fetch accepts the redirect
//   cpsr_out                 current flag register
//   stall_id, pend_full      hold decode / in-flight counter at maximum
//   redirect_valid/_pc       redirect request and latched target
//   flush_if                 kill IF/ID contents
//   illegal_cond             pulse when an unknown condition is evaluated
//   taken_cnt                wrapping count of taken jumps
// Condition codes: JMP=0 JEQ=1 JNE=2 JGE=3 JLT=4 JGT=5 JLE=6, others illegal.
module branch_ctrl #(
  parameter int ADDR_W       = 16,
  parameter int PEND_W       = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_is_jmp,
  input  logic [3:0]        id_cond,
  input  logic [ADDR_W-1:0] id_target,
  input  logic              flag_issue,
  input  logic              flag_wr_en,
  input  logic [3:0]        flag_wr_data,
  input  logic              redirect_ready,
  output logic [3:0]        cpsr_out,
  output logic              stall_id,
  output logic              pend_full,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_if,
  output logic              illegal_cond,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic [3:0] COND_JMP = 4'h0;
  localparam logic [3:0] COND_JEQ = 4'h1;
  localparam logic [3:0] COND_JNE = 4'h2;
  localparam logic [3:0] COND_JGE = 4'h3;
  localparam logic [3:0] COND_JLT = 4'h4;
  localparam logic [3:0] COND_JGT = 4'h5;
  localparam logic [3:0] COND_JLE = 4'h6;

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, REDIRECT, FLUSH} state_t;

  state_t            state, next_state;
  logic [3:0]        cpsr;
  logic [PEND_W-1:0] pending;
  logic [FC_W-1:0]   flush_cnt;

  logic              jump;
  logic [3:0]        fwd_flags;
  logic [3:0]        eval_flags;
  logic              do_eval;
  logic              cond_legal;
  logic              cond_taken;
  logic              pend_inc;
  logic              pend_dec;

  // Returns {legal, taken}; illegal codes are never taken.
  function automatic logic [1:0] cond_check(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v;
    n = f[3];
    z = f[2];
    v = f[0];
    case (c)
      COND_JMP: cond_check = 2'b11;
      COND_JEQ: cond_check = {1'b1, z};
      COND_JNE: cond_check = {1'b1, ~z};
      COND_JGE: cond_check = {1'b1, n == v};
      COND_JLT: cond_check = {1'b1, n != v};
      COND_JGT: cond_check = {1'b1, ~z & (n == v)};
      COND_JLE: cond_check = {1'b1, z | (n != v)};
      default:  cond_check = 2'b00;
    endcase
  endfunction

  assign jump      = id_valid & id_is_jmp;
  assign fwd_flags = flag_wr_en ? flag_wr_data : cpsr;
  assign cpsr_out  = cpsr;
  assign pend_full = (pending == '1);
  assign pend_dec  = flag_wr_en & (pending != '0);
  assign pend_inc  = flag_issue & ~pend_full;

  always_comb begin
    next_state     = state;
    stall_id       = 1'b0;
    flush_if       = 1'b0;
    redirect_valid = 1'b0;
    do_eval        = 1'b0;
    eval_flags     = fwd_flags;
    case (state)
      IDLE: begin
        if (jump) begin
          if (id_cond == COND_JMP || (pending == '0 && !flag_issue)) do_eval = 1'b1;
          else next_state = WAIT;
        end
      end
      WAIT: begin
        stall_id = 1'b1;
        if (!jump) begin
          next_state = IDLE;
        end else if (pending == PEND_W'(1) && flag_wr_en && !flag_issue) begin
          do_eval = 1'b1;
        end else if (pending == '0) begin
          do_eval    = 1'b1;
          eval_flags = cpsr;
        end
      end
      REDIRECT: begin
        stall_id       = 1'b1;
        flush_if       = 1'b1;
        redirect_valid = 1'b1;
        if (redirect_ready) next_state = FLUSH;
      end
      FLUSH: begin
        flush_if = 1'b1;
        if (flush_cnt == '0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    {cond_legal, cond_taken} = cond_check(id_cond, eval_flags);
    illegal_cond = do_eval & ~cond_legal;
    if (do_eval) next_state = cond_taken ? REDIRECT : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cpsr        <= '0;
      pending     <= '0;
      flush_cnt   <= '0;
      redirect_pc <= '0;
      taken_cnt   <= '0;
    end else begin
      state <= next_state;
      if (flag_wr_en) cpsr <= flag_wr_data;
      pending <= pending - PEND_W'(pend_dec) + PEND_W'(pend_inc);
      if (do_eval && cond_taken) begin
        redirect_pc <= id_target;
        taken_cnt   <= taken_cnt + 1'b1;
      end
      if (state == REDIRECT && redirect_ready)
        flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
      else if (state == FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

  localparam int ADDR_W = 16;
  localparam int PEND_W = 2;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W = 16;
  localparam int PMAX = (1 << PEND_W) - 1;

  localparam logic [3:0] C_JMP = 4'h0, C_JEQ = 4'h1, C_JNE = 4'h2, C_JGE = 4'h3,
                         C_JLT = 4'h4, C_JGT = 4'h5, C_JLE = 4'h6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0, id_is_jmp = 1'b0;
  logic [3:0] id_cond = '0;
  logic [ADDR_W-1:0] id_target = '0;
  logic flag_issue = 1'b0, flag_wr_en = 1'b0;
  logic [3:0] flag_wr_data = '0;
  logic redirect_ready = 1'b0;

  logic [3:0] cpsr_out;
  logic stall_id, pend_full, redirect_valid, flush_if, illegal_cond;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0] taken_cnt;

  int checks = 0;
  int passes = 0;

  branch_ctrl #(.ADDR_W(ADDR_W), .PEND_W(PEND_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_jmp(id_is_jmp), .id_cond(id_cond),
    .id_target(id_target), .flag_issue(flag_issue), .flag_wr_en(flag_wr_en),
    .flag_wr_data(flag_wr_data), .redirect_ready(redirect_ready), .cpsr_out(cpsr_out),
    .stall_id(stall_id), .pend_full(pend_full), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_if(flush_if), .illegal_cond(illegal_cond),
    .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: what the sequencer is doing, in plain terms.
  logic [3:0] m_cpsr;
  int m_pend, m_fleft;
  bit m_waiting, m_redirecting, m_flushing;
  logic [ADDR_W-1:0] m_pc;
  logic [CNT_W-1:0] m_cnt;
  bit e_stall, e_flush, e_rv, e_ill, e_eval, e_taken, e_to_wait;

  function automatic int cond_res(logic [3:0] c, logic [3:0] f);
    bit z, lt;
    z = f[2];
    lt = (f[3] != f[0]);
    case (c)
      C_JMP: return 1;
      C_JEQ: return int'(z);
      C_JNE: return int'(!z);
      C_JGE: return int'(!lt);
      C_JLT: return int'(lt);
      C_JGT: return int'(!z && !lt);
      C_JLE: return int'(z || lt);
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_cpsr = '0; m_pend = 0; m_fleft = 0;
    m_waiting = 0; m_redirecting = 0; m_flushing = 0;
    m_pc = '0; m_cnt = '0;
  endtask

  task automatic model_eval();
    int r;
    bit jump;
    r = 0;
    jump = id_valid && id_is_jmp;
    e_stall = 0; e_flush = 0; e_rv = 0; e_ill = 0; e_eval = 0; e_taken = 0; e_to_wait = 0;
    if (m_redirecting) begin
      e_stall = 1; e_flush = 1; e_rv = 1;
    end else if (m_flushing) begin
      e_flush = 1;
    end else if (m_waiting) begin
      e_stall = 1;
      if (jump && m_pend == 1 && flag_wr_en && !flag_issue) begin
        e_eval = 1; r = cond_res(id_cond, flag_wr_data);
      end else if (jump && m_pend == 0) begin
        e_eval = 1; r = cond_res(id_cond, m_cpsr);
      end
    end else if (jump) begin
      if (id_cond == C_JMP || (m_pend == 0 && !flag_issue)) begin
        e_eval = 1; r = cond_res(id_cond, flag_wr_en ? flag_wr_data : m_cpsr);
      end else e_to_wait = 1;
    end
    e_ill = e_eval && (r < 0);
    e_taken = e_eval && (r == 1);
  endtask

  task automatic model_update();
    bit jump;
    jump = id_valid && id_is_jmp;
    m_pend = m_pend - ((flag_wr_en && m_pend > 0) ? 1 : 0) + ((flag_issue && m_pend < PMAX) ? 1 : 0);
    if (flag_wr_en) m_cpsr = flag_wr_data;
    if (m_redirecting) begin
      if (redirect_ready) begin m_redirecting = 0; m_flushing = 1; m_fleft = FLUSH_CYCLES - 1; end
    end else if (m_flushing) begin
      if (m_fleft == 0) m_flushing = 0; else m_fleft--;
    end else if (e_eval) begin
      m_waiting = 0;
      if (e_taken) begin m_pc = id_target; m_cnt = m_cnt + 1'b1; m_redirecting = 1; end
    end else if (m_waiting && !jump) begin
      m_waiting = 0;
    end else if (e_to_wait) begin
      m_waiting = 1;
    end
  endtask

  function automatic logic [39:0] dut_vec();
    return {cpsr_out, stall_id, pend_full, redirect_valid, redirect_pc, flush_if, illegal_cond, taken_cnt};
  endfunction

  function automatic logic [39:0] exp_vec();
    return {m_cpsr, e_stall, (m_pend == PMAX), e_rv, m_pc, e_flush, e_ill, m_cnt};
  endfunction

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_is_jmp = 0; id_cond = '0; id_target = '0;
    flag_issue = 0; flag_wr_en = 0; flag_wr_data = '0; redirect_ready = 1;
  endtask

  task automatic idle_cycles(int n);
    clear_inputs();
    for (int i = 0; i < n; i++) begin sample(); advance(); end
  endtask

  task automatic present_jump(logic [3:0] c, logic [ADDR_W-1:0] t);
    id_valid = 1; id_is_jmp = 1; id_cond = c; id_target = t;
  endtask

  task automatic test_reset();
    clear_inputs();
    redirect_ready = 0;
    rst = 1;
    model_reset();
    @(negedge clk);
    checks++;
    if (dut_vec() !== 40'h0) $display("FAIL reset_state: got %h want 0", dut_vec());
    else passes++;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_uncond();
    int flushes;
    flushes = 0;
    present_jump(C_JMP, 16'h0040);
    redirect_ready = 1;
    sample();
    checks++;
    if (redirect_valid !== 1'b0 || stall_id !== 1'b0) $display("FAIL uncond_present: rv=%b stall=%b want 0 0", redirect_valid, stall_id);
    else passes++;
    advance();
    id_valid = 0;
    for (int i = 0; i < 5; i++) begin
      sample();
      checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL uncond_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
      else passes++;
      if (i == 0) begin
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0040) $display("FAIL uncond_redirect: rv=%b pc=%h want 1 0040", redirect_valid, redirect_pc);
        else passes++;
      end
      if (flush_if === 1'b1) flushes++;
      advance();
    end
    checks++;
    if (flushes != 1 + FLUSH_CYCLES || taken_cnt !== 16'd1) $display("FAIL uncond_flush_cnt: flush=%0d cnt=%0d want %0d 1", flushes, taken_cnt, 1 + FLUSH_CYCLES);
    else passes++;
  endtask

  task automatic test_eq_ne();
    for (int k = 0; k < 2; k++) begin
      clear_inputs();
      flag_wr_en = 1; flag_wr_data = 4'b0100;
      sample(); advance();
      flag_wr_en = 0;
      present_jump(k == 0 ? C_JEQ : C_JNE, 16'h0100);
      sample();
      checks++;
      if (stall_id !== 1'b0 || dut_vec() !== exp_vec()) $display("FAIL eqne_eval%0d: got %h want %h", k, dut_vec(), exp_vec());
      else passes++;
      advance();
      id_valid = 0;
      sample();
      checks++;
      if (redirect_valid !== (k == 0) || stall_id !== (k == 0)) $display("FAIL eqne_result%0d: rv=%b stall=%b want %0d", k, redirect_valid, stall_id, k == 0);
      else passes++;
      advance();
      idle_cycles(4);
    end
  endtask

  task automatic test_wait_fwd();
    clear_inputs();
    flag_issue = 1;
    sample(); advance();
    flag_issue = 0;
    present_jump(C_JLT, 16'h0200);
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++;
      if (dut_vec() !== exp_vec() || (i > 0 && stall_id !== 1'b1)) $display("FAIL wait_stall%0d: got %h want %h", i, dut_vec(), exp_vec());
      else passes++;
      advance();
    end
    flag_wr_en = 1; flag_wr_data = 4'b1000;
    sample();
    checks++;
    if (stall_id !== 1'b1 || redirect_valid !== 1'b0) $display("FAIL wait_wb: stall=%b rv=%b want 1 0", stall_id, redirect_valid);
    else passes++;
    advance();
    flag_wr_en = 0; id_valid = 0;
    sample();
    checks++;
    if (redirect_valid !== 1'b1 || cpsr_out !== 4'b1000 || redirect_pc !== 16'h0200) $display("FAIL wait_redirect: rv=%b cpsr=%b pc=%h want 1 1000 0200", redirect_valid, cpsr_out, redirect_pc);
    else passes++;
    advance();
    idle_cycles(4);
  endtask

  task automatic test_ready_hold();
    clear_inputs();
    redirect_ready = 0;
    present_jump(C_JMP, 16'h1234);
    sample(); advance();
    id_valid = 0;
    for (int i = 0; i < 4; i++) begin
      sample();
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 16'h1234 || flush_if !== 1'b1 || dut_vec() !== exp_vec())
        $display("FAIL hold%0d: got %h want %h", i, dut_vec(), exp_vec());
      else passes++;
      advance();
    end
    redirect_ready = 1;
    sample(); advance();
    redirect_ready = 0;
    sample();
    checks++;
    if (redirect_valid !== 1'b0 || flush_if !== 1'b1 || stall_id !== 1'b0) $display("FAIL hold_flush: rv=%b flush=%b stall=%b want 0 1 0", redirect_valid, flush_if, stall_id);
    else passes++;
    advance();
    idle_cycles(4);
  endtask

  task automatic test_pending();
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      flag_issue = 1;
      sample();
      checks++;
      if (pend_full !== (k == 3)) $display("FAIL pend_issue%0d: full=%b want %0d", k, pend_full, k == 3);
      else passes++;
      advance();
    end
    flag_issue = 0; flag_wr_en = 1; flag_wr_data = 4'b0011;
    sample(); advance();
    flag_issue = 1; flag_wr_en = 1;
    sample(); advance();
    flag_wr_en = 0;
    sample();
    checks++;
    if (pend_full !== 1'b0) $display("FAIL pend_both: full=%b want 0", pend_full);
    else passes++;
    advance();
    flag_issue = 0;
    sample();
    checks++;
    if (pend_full !== 1'b1 || dut_vec() !== exp_vec()) $display("FAIL pend_refill: got %h want %h", dut_vec(), exp_vec());
    else passes++;
    flag_wr_en = 1;
    for (int i = 0; i < 3; i++) begin sample(); advance(); end
    flag_wr_en = 0;
    present_jump(4'hF, 16'h0300);
    sample();
    checks++;
    if (illegal_cond !== 1'b1 || stall_id !== 1'b0) $display("FAIL illegal_pulse: ill=%b stall=%b want 1 0", illegal_cond, stall_id);
    else passes++;
    advance();
    id_valid = 0;
    sample();
    checks++;
    if (illegal_cond !== 1'b0 || redirect_valid !== 1'b0 || dut_vec() !== exp_vec()) $display("FAIL illegal_after: got %h want %h", dut_vec(), exp_vec());
    else passes++;
    advance();
  endtask

  task automatic test_reset_midflight();
    clear_inputs();
    redirect_ready = 0;
    present_jump(C_JMP, 16'h0ABC);
    sample(); advance();
    id_valid = 0;
    sample();
    #1 rst = 1; clear_inputs(); model_reset();
    #1;
    checks++;
    if (dut_vec() !== 40'h0) $display("FAIL reset_in_redirect: got %h want 0", dut_vec());
    else passes++;
    @(posedge clk); #1 rst = 0;
    flag_wr_en = 1; flag_wr_data = 4'b1111;
    sample(); advance();
    flag_wr_en = 0; flag_issue = 1;
    sample(); advance();
    flag_issue = 0;
    present_jump(C_JEQ, 16'h0555);
    sample(); advance();
    sample();
    checks++;
    if (stall_id !== 1'b1) $display("FAIL wait_before_reset: stall=%b want 1", stall_id);
    else passes++;
    #1 rst = 1; clear_inputs(); model_reset();
    #1;
    checks++;
    if (dut_vec() !== 40'h0) $display("FAIL reset_in_wait: got %h want 0", dut_vec());
    else passes++;
    @(posedge clk); #1 rst = 0;
    present_jump(C_JMP, 16'h0040);
    sample(); advance();
    id_valid = 0;
    sample();
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0040 || taken_cnt !== 16'd1) $display("FAIL post_reset_jump: rv=%b pc=%h cnt=%0d want 1 0040 1", redirect_valid, redirect_pc, taken_cnt);
    else passes++;
    advance();
    idle_cycles(4);
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!(id_valid && $urandom_range(0, 3) != 0)) begin
        id_valid = ($urandom_range(0, 2) != 0);
        id_is_jmp = ($urandom_range(0, 3) != 0);
        id_cond = ($urandom_range(0, 9) == 0) ? 4'(($urandom_range(7, 15))) : 4'($urandom_range(0, 6));
        id_target = 16'($urandom);
      end
      flag_issue = ($urandom_range(0, 3) == 0);
      flag_wr_en = ($urandom_range(0, 2) == 0);
      flag_wr_data = 4'($urandom);
      redirect_ready = ($urandom_range(0, 1) == 1);
      sample();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        if (errs < 10) $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
        errs++;
      end else passes++;
      advance();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_uncond();
    test_eq_ne();
    test_wait_fwd();
    test_ready_hold();
    test_pending();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequences conditional jumps for the pipeline.
- Owns the architectural CPSR flag register (N,Z,C,V) and tracks in-flight flag-setting instructions.
- Stalls decode until the flags a jump depends on are final, then evaluates the condition and issues a fetch redirect with a handshake, followed by a fixed-length IF/ID flush.
- Sits between decode, the ALU flag write-back and the fetch unit.

Parameters:
- ADDR_W, 16, width of PCs and jump targets.
- PEND_W, 2, width of the in-flight flag-writer counter; maximum count is 2^PEND_W-1.
- FLUSH_CYCLES, 2, number of cycles flush_if stays high after redirect acceptance; must be ≥1.
- CNT_W, 16, width of the taken-jump statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode holds a valid instruction.
- id_is_jmp  in  1  decode instruction is a jump.
- id_cond  in  4  jump condition, using the `COND_*` codes in defines.v.
- id_target  in  ADDR_W  jump target address.
- flag_issue  in  1  a flag-setting instruction leaves decode this cycle.
- flag_wr_en  in  1  a flag-setting instruction writes back this cycle.
- flag_wr_data  in  4  new flags {N,Z,C,V}.
- redirect_ready  in  1  fetch accepts the redirect.
- cpsr_out  out  4  current flag register.
- stall_id  out  1  hold decode.
- pend_full  out  1  in-flight counter at maximum; decode must not issue another flag writer.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  ADDR_W  latched jump target.
- flush_if  out  1  kill IF/ID contents.
- illegal_cond  out  1  one-cycle pulse when an unknown cond is evaluated.
- taken_cnt  out  CNT_W  count of taken jumps, wraps.

Behaviour:
- Reset (asynchronous):
  - Returns to IDLE.
  - cpsr=0, pending=0, taken_cnt=0, redirect_pc=0.
  - All single-bit outputs are 0.
  - Any redirect or flush in progress is abandoned.
- Flag register:
  - On flag_wr_en, cpsr <= flag_wr_data.
  - Effective flags F = flag_wr_en ? flag_wr_data : cpsr (same-cycle forwarding).
- Pending counter:
  - +1 on flag_issue, -1 on flag_wr_en; both in the same cycle means no change.
  - Issue while full is ignored (saturates). Write-back while zero is ignored.
  - pend_full = (pending == max).
  - Effective pending P = pending - (flag_wr_en && pending != 0) + (flag_issue && !pend_full).
- Condition evaluation (with n,z,v from F):
  - JMP = 1; JEQ = z; JNE = !z.
  - JGE = (n == v); JLT = (n != v).
  - JGT = !z && n == v; JLE = z || n != v.
  - Any other code: not taken, and illegal_cond pulses in the evaluation cycle.
- Evaluation happens only while id_valid && id_is_jmp. Evaluate means: if taken, latch redirect_pc <= id_target, increment taken_cnt, and go to REDIRECT; if not taken, stay in or return to IDLE.
- States:
  - IDLE, stall_id=0:
    - Jump with cond==JMP, or with pending==0 and !flag_issue: evaluate this cycle.
    - Otherwise go to WAIT (flags not final).
  - WAIT, stall_id=1:
    - When pending==1, flag_wr_en=1 and flag_issue=0: evaluate with forwarded data this cycle.
    - When pending==0: evaluate with cpsr.
    - flag_issue is not expected while stalled; if it occurs, it is counted and WAIT continues.
    - If id_valid drops while in WAIT, return to IDLE without evaluating.
  - REDIRECT, stall_id=1, flush_if=1, redirect_valid=1:
    - redirect_pc stays stable until redirect_ready.
    - On redirect_valid && redirect_ready, go to FLUSH and load the flush counter with FLUSH_CYCLES-1.
  - FLUSH, flush_if=1, stall_id=0, redirect_valid=0:
    - Counter decrements each cycle; at 0, go to IDLE.
    - A jump in decode during FLUSH is ignored because it is being flushed.
- Latency:
  - Unconditional taken jump: redirect_valid is high the cycle after the jump is presented.
  - Jump waiting on a write-back: redirect_valid is high the cycle after that write-back.
- taken_cnt wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset, then cond=`COND_JMP`, id_target=0x0040, redirect_ready=1 → next cycle redirect_valid=1 with redirect_pc=0x0040; flush_if high for 1+2 cycles; taken_cnt=1.
- flag_wr_en with data 4'b0100 (Z=1); next cycle `COND_JEQ` with pending=0 → taken. Same setup with `COND_JNE` → no redirect, stall_id stays 0.
- flag_issue, then `COND_JLT` in decode for 3 cycles → stall_id=1; flag_wr_en with 4'b1000 (N=1,V=0) → evaluated in that cycle; redirect next cycle; cpsr_out=4'b1000.
- redirect_ready held 0 for 4 cycles → redirect_valid and redirect_pc (0x1234) stable throughout; FLUSH starts only after ready.
- Issue 4 flag writers with PEND_W=2 → pend_full after the 3rd, 4th ignored; flag_issue and flag_wr_en together → count unchanged; cond=4'hF evaluated → illegal_cond pulse, no redirect.
- Assert rst during REDIRECT and again during WAIT → all outputs 0 immediately, cpsr=0, state IDLE; the next jump behaves as from clean reset.
